// File: rtl/nand_bist_pkg.sv
// Shared definitions for the NAND-only gate built-in self tester:
// gate-select codes, the sequencer state encoding and a legal-mode check.
package nand_bist_pkg;

  localparam logic [2:0] MODE_NOT  = 3'd0;
  localparam logic [2:0] MODE_AND  = 3'd1;
  localparam logic [2:0] MODE_OR   = 3'd2;
  localparam logic [2:0] MODE_NOR  = 3'd3;
  localparam logic [2:0] MODE_XOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Codes 6 and 7 have no gate behind them.
  function automatic logic mode_is_legal(input logic [2:0] mode);
    return (mode <= MODE_XNOR);
  endfunction

endpackage

// File: rtl/nand_gate_net.sv
// Purely combinational gate library built only from 2-input NAND gates,
// applied bitwise across WIDTH-bit operands. Mode selects which gate
// drives y; unused codes drive zero.
module nand_gate_net
  import nand_bist_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] y
);

  // The one primitive every gate below is allowed to use.
  function automatic logic [WIDTH-1:0] nand2(input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] z);
    return ~(x & z);
  endfunction

  logic [WIDTH-1:0] n_aa, n_bb, n_ab;
  logic [WIDTH-1:0] g_and, g_or, g_nor;
  logic [WIDTH-1:0] x_a, x_b, g_xor, g_xnor;

  assign n_aa   = nand2(a, a);          // NOT a
  assign n_bb   = nand2(b, b);          // NOT b
  assign n_ab   = nand2(a, b);
  assign g_and  = nand2(n_ab, n_ab);
  assign g_or   = nand2(n_aa, n_bb);
  assign g_nor  = nand2(g_or, g_or);
  // Classic 4-NAND XOR: shared nand(a,b) feeds both side gates.
  assign x_a    = nand2(a, n_ab);
  assign x_b    = nand2(b, n_ab);
  assign g_xor  = nand2(x_a, x_b);
  assign g_xnor = nand2(g_xor, g_xor);

  // Select the requested gate output.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves y
    // unassigned, which would infer a latch.
    y = '0;
    case (mode)
      MODE_NOT:  y = n_aa;
      MODE_AND:  y = g_and;
      MODE_OR:   y = g_or;
      MODE_NOR:  y = g_nor;
      MODE_XOR:  y = g_xor;
      MODE_XNOR: y = g_xnor;
      default:   y = '0;
    endcase
  end

endmodule

// File: rtl/nand_gate_bist.sv
// Built-in self tester for the NAND-only gate network. A start request
// sweeps every (a, b) operand pair through the network, compares each
// result against a behavioural gate and counts mismatches, then pulses
// done with a pass verdict. inj_mask lets a test deliberately corrupt
// the network output to prove the checker catches faults.
module nand_gate_bist
  import nand_bist_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           mode,
  input  logic [WIDTH-1:0]     inj_mask,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic [WIDTH-1:0]     vec_a,
  output logic [WIDTH-1:0]     vec_b,
  output logic [WIDTH-1:0]     y_dut,
  output logic [WIDTH-1:0]     y_ref
);

  localparam int CW    = 2 * WIDTH;
  localparam int ERR_W = 2 * WIDTH + 1;

  state_t           state;
  logic [CW-1:0]    vec_cnt;
  logic [2:0]       mode_q;
  logic [WIDTH-1:0] mask_q;
  logic             legal_q;
  logic [WIDTH-1:0] y_net;
  logic             mismatch;

  // Upper half of the counter is operand a, lower half operand b.
  assign vec_a = vec_cnt[CW-1:WIDTH];
  assign vec_b = vec_cnt[WIDTH-1:0];

  nand_gate_net #(.WIDTH(WIDTH)) u_net (
    .a    (vec_a),
    .b    (vec_b),
    .mode (mode_q),
    .y    (y_net)
  );

  assign y_dut    = y_net ^ mask_q;
  assign mismatch = (y_dut != y_ref);

  // Behavioural reference for the latched gate.
  always_comb begin
    y_ref = '0;
    case (mode_q)
      MODE_NOT:  y_ref = ~vec_a;
      MODE_AND:  y_ref = vec_a & vec_b;
      MODE_OR:   y_ref = vec_a | vec_b;
      MODE_NOR:  y_ref = ~(vec_a | vec_b);
      MODE_XOR:  y_ref = vec_a ^ vec_b;
      MODE_XNOR: y_ref = ~(vec_a ^ vec_b);
      default:   y_ref = '0;
    endcase
  end

  // Sweep sequencer: IDLE waits for start, RUN walks every vector while
  // counting mismatches, DONE pulses done and settles the verdict.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here, including the stimulus counter and the
    // latched mode/mask, is reset so a mid-sweep reset leaves no stale
    // state behind.
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      vec_cnt   <= '0;
      mode_q    <= MODE_NOT;
      mask_q    <= '0;
      legal_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register in
      // this block updates from the same pre-edge values.
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_count <= '0;
            pass      <= 1'b0;
            if (mode_is_legal(mode)) begin
              mode_q  <= mode;
              mask_q  <= inj_mask;
              vec_cnt <= '0;
              legal_q <= 1'b1;
              busy    <= 1'b1;
              state   <= ST_RUN;
            end else begin
              legal_q <= 1'b0;
              done    <= 1'b1;
              state   <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (mismatch) begin
            err_count <= err_count + ERR_W'(1);
          end
          // The all-ones vector wraps the counter back to zero.
          vec_cnt <= vec_cnt + CW'(1);
          if (&vec_cnt) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          pass  <= legal_q && (err_count == '0);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
